pl_trap_ctrl: RTL and testbench

PL_TRAP_CTRL -- requirements
Module: pl_trap_ctrl

---
 rtl/pl_trap_ctrl.sv | 126 ++++++++++++
 tb/tb_pl_trap_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pl_trap_ctrl.sv
// Pipeline trap/interrupt sequencer: accepts one trap, interrupt or mret in IDLE
// and walks FLUSH -> SAVE -> REDIR (or RET) with fully registered control outputs.
module pl_trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_ex_v,
  input  logic        trap_ex_is_intr,
  input  logic [3:0]  trap_ex_cause,
  input  logic [31:0] trap_ex_pc,
  input  logic        trap_id_v,
  input  logic [3:0]  trap_id_cause,
  input  logic [31:0] trap_id_pc,
  input  logic        irq_ext,
  input  logic [31:0] irq_pc,
  input  logic        mie,
  input  logic [31:0] mtvec,
  input  logic        mret_v,
  output logic        flush,
  output logic        stall,
  output logic        csr_we,
  output logic [31:0] mepc_out,
  output logic [31:0] mcause_out,
  output logic        redirect_v,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, FLUSH, SAVE, REDIR, RET} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cause;
    logic        intr;
  } trap_rec_t;

  state_t      state;
  trap_rec_t   lat;
  trap_rec_t   evt;
  logic        evt_trap;
  logic        evt_ret;
  logic [31:0] saved_epc;
  logic [31:0] vec_base;
  logic [31:0] vec_pc;
  logic [31:0] epc_al;

  // Priority select among the pending events; mret loses to any trap.
  always_comb begin
    evt      = '0;
    evt_trap = 1'b0;
    evt_ret  = 1'b0;
    if (trap_ex_v) begin
      evt_trap = 1'b1;
      evt      = '{pc: trap_ex_pc, cause: trap_ex_cause, intr: trap_ex_is_intr};
    end else if (trap_id_v) begin
      evt_trap = 1'b1;
      evt      = '{pc: trap_id_pc, cause: trap_id_cause, intr: 1'b0};
    end else if (irq_ext && mie) begin
      evt_trap = 1'b1;
      evt      = '{pc: irq_pc, cause: 4'd11, intr: 1'b1};
    end else if (mret_v) begin
      evt_ret  = 1'b1;
    end
  end

  assign epc_al   = {lat.pc[31:2], 2'b00};
  assign vec_base = {mtvec[31:2], 2'b00};
  // Vectored mode only offsets interrupts; the sum wraps at 32 bits.
  assign vec_pc   = (mtvec[1:0] == 2'b01 && lat.intr) ?
                    vec_base + {26'd0, lat.cause, 2'b00} : vec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat         <= '0;
      saved_epc   <= '0;
      flush       <= 1'b0;
      stall       <= 1'b0;
      csr_we      <= 1'b0;
      redirect_v  <= 1'b0;
      busy        <= 1'b0;
      mepc_out    <= '0;
      mcause_out  <= '0;
      redirect_pc <= '0;
    end else begin
      flush      <= 1'b0;
      csr_we     <= 1'b0;
      redirect_v <= 1'b0;
      case (state)
        IDLE: begin
          if (evt_trap) begin
            state <= FLUSH;
            lat   <= evt;
            flush <= 1'b1;
            stall <= 1'b1;
            busy  <= 1'b1;
          end else if (evt_ret) begin
            state       <= RET;
            flush       <= 1'b1;
            redirect_v  <= 1'b1;
            redirect_pc <= saved_epc;
            stall       <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FLUSH: begin
          state      <= SAVE;
          csr_we     <= 1'b1;
          mepc_out   <= epc_al;
          mcause_out <= {lat.intr, 27'd0, lat.cause};
          saved_epc  <= epc_al;
        end
        SAVE: begin
          state       <= REDIR;
          redirect_v  <= 1'b1;
          redirect_pc <= vec_pc;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pl_trap_ctrl.sv
// Scoreboard bench for pl_trap_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them or demands an idle controller.
module tb_pl_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_ex_v = 1'b0, trap_ex_is_intr = 1'b0;
  logic [3:0]  trap_ex_cause = '0, trap_id_cause = '0;
  logic [31:0] trap_ex_pc = '0, trap_id_pc = '0, irq_pc = '0, mtvec = '0;
  logic        trap_id_v = 1'b0, irq_ext = 1'b0, mie = 1'b0, mret_v = 1'b0;
  logic        flush, stall, csr_we, redirect_v, busy;
  logic [31:0] mepc_out, mcause_out, redirect_pc;

  pl_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_ex_v(trap_ex_v), .trap_ex_is_intr(trap_ex_is_intr),
    .trap_ex_cause(trap_ex_cause), .trap_ex_pc(trap_ex_pc),
    .trap_id_v(trap_id_v), .trap_id_cause(trap_id_cause), .trap_id_pc(trap_id_pc),
    .irq_ext(irq_ext), .irq_pc(irq_pc), .mie(mie), .mtvec(mtvec), .mret_v(mret_v),
    .flush(flush), .stall(stall), .csr_we(csr_we),
    .mepc_out(mepc_out), .mcause_out(mcause_out),
    .redirect_v(redirect_v), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        flush;
    logic        csr_we;
    logic        redirect_v;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input int c, input logic f, input logic w, input logic r,
                               input logic [31:0] m, input logic [31:0] mc, input logic [31:0] rp);
    exp_t e;
    e.cyc = c; e.flush = f; e.csr_we = w; e.redirect_v = r;
    e.mepc = m; e.mcause = mc; e.rpc = rp;
    q.push_back(e);
  endfunction

  function automatic void exp_trap(input int c, input logic [31:0] m, input logic [31:0] mc,
                                   input logic [31:0] rp);
    push(c,     1'b1, 1'b0, 1'b0, '0, '0, '0);
    push(c + 1, 1'b0, 1'b1, 1'b0, m, mc, '0);
    push(c + 2, 1'b0, 1'b0, 1'b1, '0, '0, rp);
  endfunction

  // Monitor: an expected cycle is compared field by field, any other cycle must be idle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      chk("ctl", {27'd0, flush, stall, csr_we, redirect_v, busy},
          {27'd0, mon_e.flush, 1'b1, mon_e.csr_we, mon_e.redirect_v, 1'b1});
      if (mon_e.csr_we) begin
        chk("mepc", mepc_out, mon_e.mepc);
        chk("mcause", mcause_out, mon_e.mcause);
      end
      if (mon_e.redirect_v) chk("redirect_pc", redirect_pc, mon_e.rpc);
    end else begin
      chk("idle_ctl", {27'd0, flush, stall, csr_we, redirect_v, busy}, 32'd0);
    end
  end

  task automatic clr();
    trap_ex_v = 1'b0; trap_ex_is_intr = 1'b0; trap_id_v = 1'b0;
    irq_ext = 1'b0; mret_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_mcause", mcause_out, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    idle(2);

    // Overflow trap, direct mode
    mtvec = 32'h200;
    trap_ex_v = 1'b1; trap_ex_cause = 4'd3; trap_ex_pc = 32'h100;
    exp_trap(cyc + 1, 32'h100, 32'h3, 32'h200);
    idle(1); clr(); idle(5);

    // Masked interrupt: no response
    irq_ext = 1'b1; mie = 1'b0; irq_pc = 32'h80;
    idle(1); clr(); idle(4);

    // mret returns to the saved epc
    mret_v = 1'b1;
    push(cyc + 1, 1'b1, 1'b0, 1'b1, '0, '0, 32'h100);
    idle(1); clr(); idle(4);

    // Simultaneous ex/id/irq: EX wins; events during busy are dropped
    mie = 1'b1;
    trap_ex_v = 1'b1; trap_ex_cause = 4'd3; trap_ex_pc = 32'h40;
    trap_id_v = 1'b1; trap_id_cause = 4'd2; trap_id_pc = 32'h44;
    irq_ext = 1'b1; irq_pc = 32'h80;
    exp_trap(cyc + 1, 32'h40, 32'h3, 32'h200);
    idle(1); clr();
    trap_id_v = 1'b1;
    idle(1); clr();
    mret_v = 1'b1;
    idle(1); clr(); idle(5);

    // Vectored external interrupt
    mtvec = 32'h1001; irq_ext = 1'b1; irq_pc = 32'h80;
    exp_trap(cyc + 1, 32'h80, 32'h8000_000B, 32'h102C);
    idle(1); clr(); idle(5);

    // Trap and mret together: trap taken, mret dropped; exception ignores vectoring
    trap_id_v = 1'b1; trap_id_cause = 4'd2; trap_id_pc = 32'h203; mret_v = 1'b1;
    exp_trap(cyc + 1, 32'h200, 32'h2, 32'h1000);
    idle(1); clr(); idle(5);

    // Interrupt-flagged EX trap, vectored target wraps past 2^32
    mtvec = 32'hFFFF_FFF1;
    trap_ex_v = 1'b1; trap_ex_is_intr = 1'b1; trap_ex_cause = 4'd5; trap_ex_pc = 32'h10;
    exp_trap(cyc + 1, 32'h10, 32'h8000_0005, 32'h4);
    idle(1); clr(); idle(5);

    // ID beats interrupt
    mtvec = 32'h200;
    trap_id_v = 1'b1; trap_id_cause = 4'd2; trap_id_pc = 32'h300;
    irq_ext = 1'b1; irq_pc = 32'h600;
    exp_trap(cyc + 1, 32'h300, 32'h2, 32'h200);
    idle(1); clr(); idle(5);

    // Interrupt beats mret; interrupt in direct mode; then mret to its epc
    irq_ext = 1'b1; irq_pc = 32'h500; mret_v = 1'b1;
    exp_trap(cyc + 1, 32'h500, 32'h8000_000B, 32'h200);
    idle(1); clr(); idle(5);
    mret_v = 1'b1;
    push(cyc + 1, 1'b1, 1'b0, 1'b1, '0, '0, 32'h500);
    idle(1); clr(); idle(4);

    // Reset during SAVE
    trap_ex_v = 1'b1; trap_ex_cause = 4'd3; trap_ex_pc = 32'h700;
    push(cyc + 1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    push(cyc + 2, 1'b0, 1'b1, 1'b0, 32'h700, 32'h3, '0);
    idle(1); clr();
    idle(1); rst = 1'b1;
    idle(1); rst = 1'b0;
    chk("midrst_mepc", mepc_out, 32'd0);
    chk("midrst_mcause", mcause_out, 32'd0);
    chk("midrst_rpc", redirect_pc, 32'd0);
    idle(3);
    mret_v = 1'b1;
    push(cyc + 1, 1'b1, 1'b0, 1'b1, '0, '0, 32'd0);
    idle(1); clr(); idle(4);
    trap_ex_v = 1'b1; trap_ex_cause = 4'd3; trap_ex_pc = 32'h104;
    exp_trap(cyc + 1, 32'h104, 32'h3, 32'h200);
    idle(1); clr(); idle(5);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expected outputs never seen, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
